// File: rtl/hazard_scoreboard.sv
//==============================================================================
// Module      : hazard_scoreboard
// Description : Register scoreboard and decode stall scheduler for in-flight
//               long-latency ops. Optional macro HAZARD_SCOREBOARD_WB_BYPASS_EN
//               lets a same-cycle writeback release the hazard immediately.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [4:0]       de_rd,
    input  logic             de_wen,
    input  logic             de_long,
    input  logic             ex_redirect,
    input  logic             wb_done,
    input  logic [4:0]       wb_rd,
    output logic             stall_de,
    output logic             bubble_ex,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] outstanding,
    output logic [31:0]      perf_stall_cnt
);

    localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]      r_pending;
    logic [CNT_W-1:0] r_outstanding;
    logic [31:0]      r_stall_cnt;

    logic [31:0] w_wb_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_pend_eff;
    logic        w_wb_clr;
    logic        w_free_slot;
    logic        w_long_wr;
    logic        w_raw;
    logic        w_waw;
    logic        w_full;
    logic        w_stall;
    logic        w_issue;

    // A writeback only counts as a clear when it retires a tracked register.
    assign w_wb_clr  = wb_done & (wb_rd != 5'd0) & r_pending[wb_rd];
    assign w_wb_mask = w_wb_clr ? (32'd1 << wb_rd) : 32'd0;

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    assign w_pend_eff  = r_pending & ~w_wb_mask;
    assign w_free_slot = w_wb_clr;
`else
    assign w_pend_eff  = r_pending;
    assign w_free_slot = 1'b0;
`endif

    assign w_long_wr = de_long & de_wen & (de_rd != 5'd0);

    assign w_raw  = (de_use_rs1 & w_pend_eff[de_rs1]) | (de_use_rs2 & w_pend_eff[de_rs2]);
    assign w_waw  = de_wen & (de_rd != 5'd0) & w_pend_eff[de_rd];
    assign w_full = w_long_wr & (r_outstanding == c_max_out) & ~w_free_slot;

    assign w_stall    = de_valid & ~ex_redirect & (w_raw | w_waw | w_full);
    assign w_issue    = de_valid & ~ex_redirect & ~w_stall & w_long_wr;
    assign w_set_mask = w_issue ? (32'd1 << de_rd) : 32'd0;

    // Set is applied after clear so a bypassed same-register reissue stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= 32'd0;
            r_outstanding <= '0;
            r_stall_cnt   <= 32'd0;
        end else begin
            r_pending <= ((r_pending & ~w_wb_mask) | w_set_mask) & ~32'd1;
            if (w_issue && !w_wb_clr) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_issue && w_wb_clr) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign stall_de       = w_stall;
    assign bubble_ex      = w_stall;
    assign pending        = r_pending;
    assign outstanding    = r_outstanding;
    assign perf_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
//==============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_use_rs1;
    logic        de_use_rs2;
    logic [4:0]  de_rd;
    logic        de_wen;
    logic        de_long;
    logic        ex_redirect;
    logic        wb_done;
    logic [4:0]  wb_rd;
    logic        stall_de;
    logic        bubble_ex;
    logic [31:0] pending;
    logic [2:0]  outstanding;
    logic [31:0] perf_stall_cnt;

    int n_cmp;
    int n_err;

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    localparam logic c_bypass = 1'b1;
`else
    localparam logic c_bypass = 1'b0;
`endif

    hazard_scoreboard #(
        .MAX_OUTSTANDING(4),
        .CNT_W          (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .de_valid      (de_valid),
        .de_rs1        (de_rs1),
        .de_rs2        (de_rs2),
        .de_use_rs1    (de_use_rs1),
        .de_use_rs2    (de_use_rs2),
        .de_rd         (de_rd),
        .de_wen        (de_wen),
        .de_long       (de_long),
        .ex_redirect   (ex_redirect),
        .wb_done       (wb_done),
        .wb_rd         (wb_rd),
        .stall_de      (stall_de),
        .bubble_ex     (bubble_ex),
        .pending       (pending),
        .outstanding   (outstanding),
        .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
        de_rd = 0; de_wen = 0; de_long = 0; ex_redirect = 0; wb_done = 0; wb_rd = 0;
    endtask

    task automatic set_de(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wen, input logic lng);
        de_valid = 1; de_rs1 = rs1; de_use_rs1 = u1; de_rs2 = rs2; de_use_rs2 = u2;
        de_rd = rd; de_wen = wen; de_long = lng;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
        n_cmp++; if (pending !== 32'd0) begin n_err++; $display("FAIL reset_pending got=%h exp=%h", pending, 32'd0); end
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        n_cmp++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_perf got=%0d exp=0", perf_stall_cnt); end
        n_cmp++; if ({stall_de, bubble_ex} !== 2'b00) begin n_err++; $display("FAIL reset_stall got=%b exp=00", {stall_de, bubble_ex}); end
    endtask

    task automatic test_raw();
        logic [31:0] exp_perf;
        do_reset();
        set_de(5'd0, 0, 5'd0, 0, 5'd5, 1, 1);       // long load rd=5
        #1;
        n_cmp++; if (stall_de !== 1'b0) begin n_err++; $display("FAIL raw_issue_stall got=%b exp=0", stall_de); end
        tick();
        n_cmp++; if (pending !== 32'h0000_0020) begin n_err++; $display("FAIL raw_pending got=%h exp=00000020", pending); end
        set_de(5'd5, 1, 5'd0, 0, 5'd10, 1, 0);      // add reads x5
        #1;
        n_cmp++; if ({stall_de, bubble_ex} !== 2'b11) begin n_err++; $display("FAIL raw_stall got=%b exp=11", {stall_de, bubble_ex}); end
        tick();
        n_cmp++; if (stall_de !== 1'b1) begin n_err++; $display("FAIL raw_stall_hold got=%b exp=1", stall_de); end
        tick();
        wb_done = 1; wb_rd = 5'd5;
        #1;
        n_cmp++; if (stall_de !== ~c_bypass) begin n_err++; $display("FAIL raw_wb_cycle_stall got=%b exp=%b", stall_de, ~c_bypass); end
        tick();
        wb_done = 0;
        #1;
        exp_perf = c_bypass ? 32'd2 : 32'd3;
        n_cmp++; if (pending !== 32'd0) begin n_err++; $display("FAIL raw_pending_clr got=%h exp=0", pending); end
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL raw_outstanding got=%0d exp=0", outstanding); end
        n_cmp++; if (stall_de !== 1'b0) begin n_err++; $display("FAIL raw_stall_released got=%b exp=0", stall_de); end
        n_cmp++; if (perf_stall_cnt !== exp_perf) begin n_err++; $display("FAIL raw_perf got=%0d exp=%0d", perf_stall_cnt, exp_perf); end
    endtask

    task automatic test_full();
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            set_de(5'd0, 0, 5'd0, 0, 5'(r), 1, 1);
            tick();
        end
        n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_outstanding got=%0d exp=4", outstanding); end
        n_cmp++; if (pending !== 32'h0000_001E) begin n_err++; $display("FAIL full_pending got=%h exp=0000001e", pending); end
        set_de(5'd0, 0, 5'd0, 0, 5'd6, 1, 1);
        #1;
        n_cmp++; if (stall_de !== 1'b1) begin n_err++; $display("FAIL full_stall got=%b exp=1", stall_de); end
        tick();
        wb_done = 1; wb_rd = 5'd2;
        #1;
        n_cmp++; if (stall_de !== ~c_bypass) begin n_err++; $display("FAIL full_wb_stall got=%b exp=%b", stall_de, ~c_bypass); end
        tick();
        wb_done = 0;
        if (!c_bypass) begin
            #1;
            n_cmp++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL full_after_wb_out got=%0d exp=3", outstanding); end
            n_cmp++; if (stall_de !== 1'b0) begin n_err++; $display("FAIL full_after_wb_stall got=%b exp=0", stall_de); end
            tick();
        end
        idle();
        #1;
        n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_final_out got=%0d exp=4", outstanding); end
        n_cmp++; if (pending !== 32'h0000_005A) begin n_err++; $display("FAIL full_final_pending got=%h exp=0000005a", pending); end
    endtask

    task automatic test_waw();
        do_reset();
        set_de(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
        tick();
        set_de(5'd1, 1, 5'd2, 1, 5'd7, 1, 0);       // ALU op writes x7
        #1;
        n_cmp++; if (stall_de !== 1'b1) begin n_err++; $display("FAIL waw_stall got=%b exp=1", stall_de); end
        tick();
        wb_done = 1; wb_rd = 5'd7;
        #1;
        n_cmp++; if (stall_de !== ~c_bypass) begin n_err++; $display("FAIL waw_wb_stall got=%b exp=%b", stall_de, ~c_bypass); end
        tick();
        wb_done = 0;
        #1;
        n_cmp++; if (stall_de !== 1'b0) begin n_err++; $display("FAIL waw_released got=%b exp=0", stall_de); end
        tick();
        n_cmp++; if ({pending, outstanding} !== {32'd0, 3'd0}) begin n_err++; $display("FAIL waw_no_set pending=%h out=%0d exp=0/0", pending, outstanding); end
    endtask

    task automatic test_x0();
        do_reset();
        set_de(5'd0, 1, 5'd0, 1, 5'd0, 1, 1);       // long op rd=0 reading x0
        #1;
        n_cmp++; if (stall_de !== 1'b0) begin n_err++; $display("FAIL x0_stall got=%b exp=0", stall_de); end
        tick();
        n_cmp++; if ({pending, outstanding} !== {32'd0, 3'd0}) begin n_err++; $display("FAIL x0_no_set pending=%h out=%0d exp=0/0", pending, outstanding); end
        set_de(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
        tick();
        idle();
        wb_done = 1; wb_rd = 5'd0;
        tick();
        n_cmp++; if ({pending, outstanding} !== {32'h10, 3'd1}) begin n_err++; $display("FAIL x0_wb_ignored pending=%h out=%0d exp=10/1", pending, outstanding); end
        wb_rd = 5'd9;
        tick();
        wb_done = 0;
        n_cmp++; if ({pending, outstanding} !== {32'h10, 3'd1}) begin n_err++; $display("FAIL wb_nonpending pending=%h out=%0d exp=10/1", pending, outstanding); end
    endtask

    task automatic test_redirect();
        do_reset();
        set_de(5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        tick();
        set_de(5'd3, 1, 5'd0, 0, 5'd8, 1, 1);       // hazardous long op rd=8
        ex_redirect = 1;
        #1;
        n_cmp++; if (stall_de !== 1'b0) begin n_err++; $display("FAIL redir_stall got=%b exp=0", stall_de); end
        tick();
        n_cmp++; if ({pending, outstanding} !== {32'h08, 3'd1}) begin n_err++; $display("FAIL redir_retain pending=%h out=%0d exp=08/1", pending, outstanding); end
        wb_done = 1; wb_rd = 5'd3;
        tick();
        idle();
        n_cmp++; if ({pending, outstanding} !== {32'd0, 3'd0}) begin n_err++; $display("FAIL redir_wb_clear pending=%h out=%0d exp=0/0", pending, outstanding); end
        n_cmp++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL redir_perf got=%0d exp=0", perf_stall_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_de(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
        tick();
        set_de(5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_de(5'd4, 1, 5'd0, 0, 5'd11, 1, 0);      // one RAW stall cycle
        tick();
        n_cmp++; if ({pending, outstanding} !== {32'h30, 3'd2}) begin n_err++; $display("FAIL rst_pre pending=%h out=%0d exp=30/2", pending, outstanding); end
        n_cmp++; if (perf_stall_cnt !== 32'd1) begin n_err++; $display("FAIL rst_pre_perf got=%0d exp=1", perf_stall_cnt); end
        set_de(5'd0, 0, 5'd0, 0, 5'd6, 1, 1);
        wb_done = 1; wb_rd = 5'd4;
        reset = 1;
        tick();
        reset = 0;
        idle();
        #1;
        n_cmp++; if ({pending, outstanding} !== {32'd0, 3'd0}) begin n_err++; $display("FAIL rst_mid pending=%h out=%0d exp=0/0", pending, outstanding); end
        n_cmp++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_mid_perf got=%0d exp=0", perf_stall_cnt); end
        n_cmp++; if (stall_de !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got=%b exp=0", stall_de); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1;
        idle();
        test_reset();
        test_raw();
        test_full();
        test_waw();
        test_x0();
        test_redirect();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
